// File: rtl/matrix_vector_engine.sv
// Streaming signed matrix-vector multiplier: y[r] = sum_c M[r][c] * V[c], row-major reads, one result write per row.
// Optional MVM_SATURATE_EN: accumulator clamps on signed overflow instead of wrapping.
module matrix_vector_engine #(
   parameter int ROWS   = 10,
   parameter int COLS   = 10,
   parameter int DATA_W = 32,
   parameter int ACC_W  = 64,
   localparam int MA_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
   localparam int VA_W  = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int YA_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              m_rd_en,
   output logic [MA_W-1:0]   m_addr,
   output logic [VA_W-1:0]   v_addr,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [DATA_W-1:0] v_rdata,
   output logic              y_we,
   output logic [YA_W-1:0]   y_addr,
   output logic [ACC_W-1:0]  y_wdata,
   output logic [31:0]       cycle_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

   localparam logic [VA_W-1:0] C_LAST = VA_W'(COLS - 1);
   localparam logic [YA_W-1:0] R_LAST = YA_W'(ROWS - 1);

   state_t state_q, state_d;
   logic [MA_W-1:0] m_addr_q, m_addr_d;
   logic [VA_W-1:0] c_q, c_d;
   logic [YA_W-1:0] r_q, r_d;
   logic [31:0]     cycle_count_q, cycle_count_d;

   // stage 1: read data returning; stage 2: product held in p_q
   logic            s1_vld_q, s1_vld_d, s1_first_q, s1_first_d;
   logic            s1_lastc_q, s1_lastc_d, s1_last_q, s1_last_d;
   logic [YA_W-1:0] s1_row_q, s1_row_d;
   logic            s2_vld_q, s2_vld_d, s2_first_q, s2_first_d;
   logic            s2_lastc_q, s2_lastc_d, s2_last_q, s2_last_d;
   logic [YA_W-1:0] s2_row_q, s2_row_d;

   logic signed [2*DATA_W-1:0] prod, p_q, p_d;
   logic signed [ACC_W-1:0]    p_ext, acc_base, acc_next, acc_q, acc_d;
   logic                       y_we_q, y_we_d, y_last_q, y_last_d;
   logic [YA_W-1:0]            y_addr_q, y_addr_d;

   logic issue, issue_lastc, issue_last;

`ifdef MVM_SATURATE_EN
   logic [ACC_W:0] sum_full;
`endif

   always_comb begin
      issue       = (state_q == RUN);
      issue_lastc = (c_q == C_LAST);
      issue_last  = issue_lastc && (r_q == R_LAST);
   end

   always_comb begin
      state_d       = state_q;
      m_addr_d      = m_addr_q;
      c_d           = c_q;
      r_d           = r_q;
      cycle_count_d = cycle_count_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = RUN;
               m_addr_d      = '0;
               c_d           = '0;
               r_d           = '0;
               cycle_count_d = '0;
            end
         end
         RUN: begin
            // counters park on the final element so addresses hold after the run
            if (issue_last) begin
               state_d = DRAIN;
            end else begin
               m_addr_d = m_addr_q + MA_W'(1);
               if (issue_lastc) begin
                  c_d = '0;
                  r_d = r_q + YA_W'(1);
               end else begin
                  c_d = c_q + VA_W'(1);
               end
            end
         end
         DRAIN: begin
            if (y_we_q && y_last_q) state_d = FINISH;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if ((state_q == RUN || state_q == DRAIN) && cycle_count_q != '1)
         cycle_count_d = cycle_count_q + 32'd1;
   end

   always_comb begin
      s1_vld_d   = issue;
      s1_first_d = issue && (c_q == '0);
      s1_lastc_d = issue && issue_lastc;
      s1_last_d  = issue && issue_last;
      s1_row_d   = r_q;
      s2_vld_d   = s1_vld_q;
      s2_first_d = s1_first_q;
      s2_lastc_d = s1_lastc_q;
      s2_last_d  = s1_last_q;
      s2_row_d   = s1_row_q;

      prod = $signed(m_rdata) * $signed(v_rdata);
      p_d  = s1_vld_q ? prod : p_q;

      p_ext    = ACC_W'(p_q);
      acc_base = s2_first_q ? '0 : acc_q;
`ifdef MVM_SATURATE_EN
      sum_full = {acc_base[ACC_W-1], acc_base} + {p_ext[ACC_W-1], p_ext};
      if (sum_full[ACC_W] != sum_full[ACC_W-1])
         acc_next = sum_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         acc_next = sum_full[ACC_W-1:0];
`else
      acc_next = acc_base + p_ext;
`endif
      acc_d = s2_vld_q ? acc_next : acc_q;

      y_we_d   = s2_vld_q && s2_lastc_q;
      y_last_d = s2_vld_q && s2_last_q;
      y_addr_d = y_we_d ? s2_row_q : y_addr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         m_addr_q      <= '0;
         c_q           <= '0;
         r_q           <= '0;
         cycle_count_q <= '0;
         s1_vld_q      <= 1'b0;
         s1_first_q    <= 1'b0;
         s1_lastc_q    <= 1'b0;
         s1_last_q     <= 1'b0;
         s1_row_q      <= '0;
         s2_vld_q      <= 1'b0;
         s2_first_q    <= 1'b0;
         s2_lastc_q    <= 1'b0;
         s2_last_q     <= 1'b0;
         s2_row_q      <= '0;
         p_q           <= '0;
         acc_q         <= '0;
         y_we_q        <= 1'b0;
         y_last_q      <= 1'b0;
         y_addr_q      <= '0;
      end else begin
         state_q       <= state_d;
         m_addr_q      <= m_addr_d;
         c_q           <= c_d;
         r_q           <= r_d;
         cycle_count_q <= cycle_count_d;
         s1_vld_q      <= s1_vld_d;
         s1_first_q    <= s1_first_d;
         s1_lastc_q    <= s1_lastc_d;
         s1_last_q     <= s1_last_d;
         s1_row_q      <= s1_row_d;
         s2_vld_q      <= s2_vld_d;
         s2_first_q    <= s2_first_d;
         s2_lastc_q    <= s2_lastc_d;
         s2_last_q     <= s2_last_d;
         s2_row_q      <= s2_row_d;
         p_q           <= p_d;
         acc_q         <= acc_d;
         y_we_q        <= y_we_d;
         y_last_q      <= y_last_d;
         y_addr_q      <= y_addr_d;
      end
   end

   assign busy        = (state_q == RUN) || (state_q == DRAIN);
   assign done        = (state_q == FINISH);
   assign m_rd_en     = issue;
   assign m_addr      = m_addr_q;
   assign v_addr      = c_q;
   assign y_we        = y_we_q;
   assign y_addr      = y_addr_q;
   assign y_wdata     = acc_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_matrix_vector_engine.sv
// Directed bench for matrix_vector_engine: four instances covering 2x3, 10x10, 3x1 and a narrow 1x4 overflow case.
module tb_matrix_vector_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance A: 2x3, 32/64
   logic        a_start, a_busy, a_done, a_rd, a_we;
   logic [2:0]  a_maddr;
   logic [1:0]  a_vaddr;
   logic [31:0] a_mr, a_vr, a_cc;
   logic [0:0]  a_ya;
   logic [63:0] a_yd;
   logic [31:0] a_M[8];
   logic [31:0] a_V[4];
   matrix_vector_engine #(.ROWS(2), .COLS(3), .DATA_W(32), .ACC_W(64)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done), .m_rd_en(a_rd),
      .m_addr(a_maddr), .v_addr(a_vaddr), .m_rdata(a_mr), .v_rdata(a_vr), .y_we(a_we),
      .y_addr(a_ya), .y_wdata(a_yd), .cycle_count(a_cc));
   always @(posedge clk) if (a_rd) begin a_mr <= a_M[a_maddr]; a_vr <= a_V[a_vaddr]; end

   // instance B: default 10x10
   logic        b_start, b_busy, b_done, b_rd, b_we;
   logic [6:0]  b_maddr;
   logic [3:0]  b_vaddr, b_ya;
   logic [31:0] b_mr, b_vr, b_cc;
   logic [63:0] b_yd;
   logic [31:0] b_M[128];
   logic [31:0] b_V[16];
   matrix_vector_engine u_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .m_rd_en(b_rd),
      .m_addr(b_maddr), .v_addr(b_vaddr), .m_rdata(b_mr), .v_rdata(b_vr), .y_we(b_we),
      .y_addr(b_ya), .y_wdata(b_yd), .cycle_count(b_cc));
   always @(posedge clk) if (b_rd) begin b_mr <= b_M[b_maddr]; b_vr <= b_V[b_vaddr]; end

   // instance C: 3x1
   logic        c_start, c_busy, c_done, c_rd, c_we;
   logic [1:0]  c_maddr, c_ya;
   logic [0:0]  c_vaddr;
   logic [31:0] c_mr, c_vr, c_cc;
   logic [63:0] c_yd;
   logic [31:0] c_M[4];
   logic [31:0] c_V[2];
   matrix_vector_engine #(.ROWS(3), .COLS(1), .DATA_W(32), .ACC_W(64)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done), .m_rd_en(c_rd),
      .m_addr(c_maddr), .v_addr(c_vaddr), .m_rdata(c_mr), .v_rdata(c_vr), .y_we(c_we),
      .y_addr(c_ya), .y_wdata(c_yd), .cycle_count(c_cc));
   always @(posedge clk) if (c_rd) begin c_mr <= c_M[c_maddr]; c_vr <= c_V[c_vaddr]; end

   // instance D: 1x4, 8/16
   logic        d_start, d_busy, d_done, d_rd, d_we;
   logic [1:0]  d_maddr, d_vaddr;
   logic [0:0]  d_ya;
   logic [7:0]  d_mr, d_vr;
   logic [31:0] d_cc;
   logic [15:0] d_yd;
   logic [7:0]  d_M[4];
   logic [7:0]  d_V[4];
   matrix_vector_engine #(.ROWS(1), .COLS(4), .DATA_W(8), .ACC_W(16)) u_d (
      .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done), .m_rd_en(d_rd),
      .m_addr(d_maddr), .v_addr(d_vaddr), .m_rdata(d_mr), .v_rdata(d_vr), .y_we(d_we),
      .y_addr(d_ya), .y_wdata(d_yd), .cycle_count(d_cc));
   always @(posedge clk) if (d_rd) begin d_mr <= d_M[d_maddr]; d_vr <= d_V[d_vaddr]; end

   int          sel, k, wr_n, done_k, done_n, rd_n, busy_n, n_checks, n_err;
   int          wr_k[16];
   int          wr_a[16];
   logic [63:0] wr_d[16];
   logic [31:0] done_cc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic clear_log();
      k = 0; wr_n = 0; done_k = -1; done_n = 0; rd_n = 0; busy_n = 0; done_cc = '0;
   endtask

   // k counts cycles after the start edge: cycle 1 is the first cycle after it
   task automatic tick();
      logic we, dn, rd, bz;
      int ya;
      logic [63:0] yd;
      logic [31:0] cc;
      @(negedge clk);
      k++;
      case (sel)
         0: begin we = a_we; dn = a_done; rd = a_rd; bz = a_busy; ya = int'(a_ya); yd = a_yd; cc = a_cc; end
         1: begin we = b_we; dn = b_done; rd = b_rd; bz = b_busy; ya = int'(b_ya); yd = b_yd; cc = b_cc; end
         2: begin we = c_we; dn = c_done; rd = c_rd; bz = c_busy; ya = int'(c_ya); yd = c_yd; cc = c_cc; end
         default: begin
            we = d_we; dn = d_done; rd = d_rd; bz = d_busy; ya = int'(d_ya);
            yd = 64'($signed(d_yd)); cc = d_cc;
         end
      endcase
      if (rd) rd_n++;
      if (bz) busy_n++;
      if (we) begin
         if (wr_n < 16) begin wr_k[wr_n] = k; wr_a[wr_n] = ya; wr_d[wr_n] = yd; end
         wr_n++;
      end
      if (dn) begin
         done_n++;
         if (done_n == 1) begin done_k = k; done_cc = cc; end
      end
   endtask

   task automatic set_start(input logic v);
      case (sel)
         0: a_start = v;
         1: b_start = v;
         2: c_start = v;
         default: d_start = v;
      endcase
   endtask

   task automatic run(input int s, input bit hold, input int budget);
      sel = s;
      clear_log();
      set_start(1'b1);
      tick();
      if (!hold) set_start(1'b0);
      while (done_n == 0 && k < budget) begin
         tick();
         if (done_n != 0) set_start(1'b0);
      end
      set_start(1'b0);
      repeat (4) tick();
   endtask

   task automatic chk_a(input string t, input longint y0, input longint y1);
      chk({t, " writes"}, wr_n, 2);
      chk({t, " y0 cycle"}, wr_k[0], 6);
      chk({t, " y0 addr"}, wr_a[0], 0);
      chk({t, " y0 data"}, wr_d[0], y0);
      chk({t, " y1 cycle"}, wr_k[1], 9);
      chk({t, " y1 addr"}, wr_a[1], 1);
      chk({t, " y1 data"}, wr_d[1], y1);
      chk({t, " done cycle"}, done_k, 10);
      chk({t, " done pulses"}, done_n, 1);
      chk({t, " cycle_count"}, done_cc, 9);
      chk({t, " reads"}, rd_n, 6);
      chk({t, " busy cycles"}, busy_n, 9);
      chk({t, " cc held"}, a_cc, 9);
      chk({t, " m_addr held"}, a_maddr, 5);
      chk({t, " v_addr held"}, a_vaddr, 2);
   endtask

   initial begin
      n_checks = 0; n_err = 0; sel = 0;
      rst = 1'b1;
      a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; d_start = 1'b0;
      for (int i = 0; i < 8; i++) a_M[i] = '0;
      for (int i = 0; i < 4; i++) a_V[i] = '0;
      for (int i = 0; i < 6; i++) a_M[i] = 32'(i + 1);
      for (int i = 0; i < 3; i++) a_V[i] = 32'd1;
      for (int i = 0; i < 128; i++) b_M[i] = '0;
      for (int i = 0; i < 10; i++) b_M[i * 11] = 32'd1;
      for (int i = 0; i < 16; i++) b_V[i] = 32'(i - 5);
      c_M[0] = 32'd2; c_M[1] = 32'd3; c_M[2] = 32'd4; c_M[3] = '0;
      c_V[0] = 32'd5; c_V[1] = '0;
      for (int i = 0; i < 4; i++) begin d_M[i] = 8'h80; d_V[i] = 8'h80; end
      clear_log();
      repeat (2) tick();

      chk("rst busy", a_busy, 0);
      chk("rst done", a_done, 0);
      chk("rst m_rd_en", a_rd, 0);
      chk("rst y_we", a_we, 0);
      chk("rst m_addr", a_maddr, 0);
      chk("rst y_wdata", a_yd, 0);
      chk("rst cycle_count", a_cc, 0);
      rst = 1'b0;
      tick();

      run(0, 1'b0, 40);
      chk_a("basic", 6, 15);

      run(0, 1'b1, 40);
      chk_a("held start", 6, 15);

      // abort mid-operation, with row 0 one cycle from being written
      sel = 0;
      clear_log();
      set_start(1'b1);
      tick();
      set_start(1'b0);
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk("abort busy", a_busy, 0);
      chk("abort m_rd_en", a_rd, 0);
      chk("abort m_addr", a_maddr, 0);
      chk("abort v_addr", a_vaddr, 0);
      chk("abort y_wdata", a_yd, 0);
      chk("abort cycle_count", a_cc, 0);
      repeat (2) tick();
      rst = 1'b0;
      clear_log();
      repeat (10) tick();
      chk("abort no writes", wr_n, 0);
      chk("abort no done", done_n, 0);
      chk("abort no reads", rd_n, 0);
      a_M[0] = -32'sd1; a_M[1] = 32'd2; a_M[2] = -32'sd3;
      a_M[3] = 32'd4;   a_M[4] = -32'sd5; a_M[5] = 32'd6;
      a_V[0] = 32'd7;   a_V[1] = -32'sd8; a_V[2] = 32'd9;
      run(0, 1'b0, 40);
      chk_a("restart", -50, 122);

      run(1, 1'b0, 200);
      chk("10x10 writes", wr_n, 10);
      chk("10x10 done cycle", done_k, 104);
      chk("10x10 reads", rd_n, 100);
      chk("10x10 cycle_count", done_cc, 103);
      for (int r = 0; r < 10; r++) begin
         chk($sformatf("10x10 y%0d cycle", r), wr_k[r], 64'(13 + 10 * r));
         chk($sformatf("10x10 y%0d addr", r), wr_a[r], 64'(r));
         chk($sformatf("10x10 y%0d data", r), wr_d[r], 64'(longint'(r - 5)));
      end

      run(2, 1'b0, 40);
      chk("3x1 writes", wr_n, 3);
      for (int r = 0; r < 3; r++) begin
         chk($sformatf("3x1 y%0d cycle", r), wr_k[r], 64'(4 + r));
         chk($sformatf("3x1 y%0d addr", r), wr_a[r], 64'(r));
         chk($sformatf("3x1 y%0d data", r), wr_d[r], 64'(10 + 5 * r));
      end
      chk("3x1 done cycle", done_k, 7);
      chk("3x1 cycle_count", done_cc, 6);
      chk("3x1 reads", rd_n, 3);

      run(3, 1'b0, 40);
      chk("1x4 writes", wr_n, 1);
      chk("1x4 y0 cycle", wr_k[0], 7);
`ifdef MVM_SATURATE_EN
      chk("1x4 y0 data", wr_d[0], 64'd32767);
`else
      chk("1x4 y0 data", wr_d[0], 64'd0);
`endif
      chk("1x4 done cycle", done_k, 8);
      chk("1x4 cycle_count", done_cc, 7);
      chk("1x4 reads", rd_n, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
